arm_seq: RTL

ARM_SEQ -- requirements
Module: arm_seq

---
 rtl/arm_pkg.sv | 20 ++
 rtl/arm_pc.sv | 24 ++
 rtl/arm_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared state encodings, opcodes and helpers for the sequencer
package arm_pkg;

  // One-hot phase encoding; the values are visible on the state port
  typedef enum logic [2:0] {
    ST_FETCH = 3'b001,
    ST_EXEC1 = 3'b010,
    ST_EXEC2 = 3'b100
  } state_t;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;

  // Sign-extend a 12-bit branch offset to the 16-bit address width
  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/arm_pc.sv
// rtl/arm_pc.sv - program counter with incrementer and relative branch adder
module arm_pc
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        branch,
  input  logic [11:0] offset,
  output logic [15:0] pc
);

  // Increment on accepted fetch, add offset on taken branch; both wrap mod 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 16'h0000;
    end else if (inc) begin
      pc <= pc + 16'h0001;
    end else if (branch) begin
      pc <= pc + sext12(offset);
    end
  end

endmodule

// File: rtl/arm_seq.sv
// rtl/arm_seq.sv - fetch/execute sequencer with instruction register and zero flag
module arm_seq
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic [15:0] alu_dout,
  output logic [15:0] inst,
  output logic [2:0]  state,
  output logic        zflag
);

  state_t      st;
  logic        pending;
  logic [15:0] pc;
  logic [3:0]  opcode;
  logic        fetch_go;
  logic        take_branch;

  assign opcode    = inst[15:12];
  assign state     = st;
  assign imem_addr = pc;

  // A request, once raised, is held by pending so dropping run cannot cancel it
  assign imem_req  = (st == ST_FETCH) & (run | pending);
  assign fetch_go  = imem_req & imem_ack;

  // JZ reads the flag as registered; the same cycle never updates it since inst[15]==0
  assign take_branch = (st == ST_EXEC1) &
                       ((opcode == OP_JMP) | ((opcode == OP_JZ) & zflag));

  arm_pc u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (fetch_go),
    .branch (take_branch),
    .offset (inst[11:0]),
    .pc     (pc)
  );

  // Track an outstanding fetch request until it is acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else begin
      pending <= imem_req & ~imem_ack;
    end
  end

  // Phase FSM, instruction register load and zero flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_FETCH;
      inst  <= 16'h0000;
      zflag <= 1'b0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (fetch_go) begin
            inst <= imem_data;
            st   <= ST_EXEC1;
          end
        end
        ST_EXEC1: begin
          if (inst[15] && (opcode != OP_LDR)) begin
            zflag <= (alu_dout == 16'h0000);
          end
          st <= (opcode == OP_LDR) ? ST_EXEC2 : ST_FETCH;
        end
        ST_EXEC2: begin
          st <= ST_FETCH;
        end
        default: begin
          st <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
